// File: rtl/dac_update_scheduler_pkg.sv
// Shared definitions for the DAC update scheduler: register map, command word
// layout and FSM state encoding.
package dac_pkg;

  localparam int MAX_CH = 8;
  localparam int CH_W   = 3;

  localparam logic [7:0]  REG_CTRL   = 8'd8;
  localparam logic [7:0]  REG_ID     = 8'd9;
  localparam logic [7:0]  REG_STATUS = 8'd10;
  localparam logic [15:0] ID_VALUE   = 16'h5EDA;

  localparam int CH_MSB  = 14;
  localparam int CH_LSB  = 12;
  localparam int VAL_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Command word to the shifter: {1'b0, channel, 12-bit value}
  function automatic logic [15:0] make_word(input logic [CH_W-1:0] ch,
                                            input logic [VAL_MSB:0] val);
    logic [15:0] w;
    w = '0;
    w[CH_MSB:CH_LSB] = ch;
    w[VAL_MSB:0]     = val;
    return w;
  endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// EBI register bus plus the valid/ready link to the DAC shifter.
interface dac_update_scheduler_if;
  import dac_pkg::*;

  logic        enable;
  logic        re;
  logic        wr;
  logic [18:0] addr;
  logic [15:0] data;
  logic [15:0] out_data;
  logic [15:0] dac_word;
  logic        dac_valid;
  logic        dac_ready;
  logic        ldac_strobe;
  logic        busy;

  modport slave (
    input  enable, re, wr, addr, data, dac_ready,
    output out_data, dac_word, dac_valid, ldac_strobe, busy
  );

  modport master (
    output enable, re, wr, addr, data, dac_ready,
    input  out_data, dac_word, dac_valid, ldac_strobe, busy
  );

endinterface

// File: rtl/dac_update_scheduler_rr_pick.sv
// Round-robin first-set finder: returns the first set bit of mask searching
// upward from start+1 and wrapping, so the channel at start is checked last.
module rr_pick
  import dac_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   start,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [MAX_CH-1:0] ext;
  logic [CH_W-1:0]   cand;

  always_comb begin
    ext   = '0;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    ext[NUM_CH-1:0] = mask;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(start) + i) % NUM_CH);
      if (!found && ext[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// Holds per-channel DAC values written over EBI and feeds dirty channels,
// round-robin, to the serial shifter; strobes LDAC when a batch drains.
module dac_update_scheduler
  import dac_pkg::*;
#(
  parameter int POSITION   = 0,
  parameter int NUM_CH     = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic                    ebi_clk,
  input logic                    nReset,
  dac_update_scheduler_if.slave  bus
);

  localparam logic [10:0] POS_SEL  = 11'(POSITION);
  localparam logic [7:0]  NUM_CH_B = 8'(NUM_CH);
  localparam logic [3:0]  GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [11:0]       value_q [MAX_CH];
  logic [MAX_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   rr_q, issue_ch_q, wr_ch, pick_idx;
  logic              sent_q, hold_q, ldac_q;
  logic [3:0]        gap_q;
  logic [15:0]       dac_word_q, out_data_q, rd_data;
  logic              cs, wr_hit, ctrl_wr, pick_found;
  logic              take, done, strobe_d;
  logic              unused_data_bits;

  assign cs       = bus.enable & (bus.addr[18:8] == POS_SEL);
  assign wr_hit   = cs & bus.wr & (bus.addr[7:0] < NUM_CH_B);
  assign ctrl_wr  = cs & bus.wr & (bus.addr[7:0] == REG_CTRL);
  assign wr_ch    = bus.addr[CH_W-1:0];
  assign unused_data_bits = ^bus.data[15:12];

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .mask  (pending_q[NUM_CH-1:0]),
    .start (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A held scheduler still lets an in-flight word finish; hold only gates new issues
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    done     = 1'b0;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hold_q && pick_found) begin
          take    = 1'b1;
          state_d = ST_ISSUE;
        end else if (pending_q == '0 && sent_q) begin
          strobe_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (bus.dac_ready) begin
          done    = 1'b1;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A write landing on the channel being issued re-arms it, so it wins here
  always_comb begin
    pending_d = pending_q;
    if (take)   pending_d[pick_idx] = 1'b0;
    if (wr_hit) pending_d[wr_ch]    = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    if (cs && bus.re) begin
      if (bus.addr[7:0] < NUM_CH_B) begin
        rd_data = {4'b0, value_q[bus.addr[CH_W-1:0]]};
      end else begin
        case (bus.addr[7:0])
          REG_CTRL:   rd_data = {15'b0, hold_q};
          REG_ID:     rd_data = ID_VALUE;
          REG_STATUS: rd_data = {8'b0, pending_q};
          default:    rd_data = '0;
        endcase
      end
    end
  end

  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < MAX_CH; i++) value_q[i] <= '0;
      pending_q  <= '0;
      hold_q     <= 1'b0;
      rr_q       <= '0;
      issue_ch_q <= '0;
      sent_q     <= 1'b0;
      gap_q      <= '0;
      dac_word_q <= '0;
      ldac_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (wr_hit)  value_q[wr_ch] <= bus.data[11:0];
      if (ctrl_wr) hold_q <= bus.data[0];
      pending_q  <= pending_d;
      ldac_q     <= strobe_d;
      out_data_q <= rd_data;
      if (take) begin
        dac_word_q <= make_word(pick_idx, value_q[pick_idx]);
        issue_ch_q <= pick_idx;
      end
      if (done) begin
        rr_q   <= issue_ch_q;
        sent_q <= 1'b1;
        gap_q  <= GAP_LOAD;
      end else begin
        if (strobe_d) sent_q <= 1'b0;
        if (state_q == ST_GAP && gap_q != 4'd0) gap_q <= gap_q - 4'd1;
      end
    end
  end

  assign bus.dac_valid   = (state_q == ST_ISSUE);
  assign bus.dac_word    = dac_word_q;
  assign bus.ldac_strobe = ldac_q;
  assign bus.out_data    = out_data_q;
  assign bus.busy        = (pending_q != '0) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler: issue order, gap timing, LDAC,
// backpressure, coalescing, readback and asynchronous reset.
module tb_dac_update_scheduler;

  logic ebi_clk = 1'b0;
  logic nReset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [15:0] words [8];
  int   word_count;
  int   strobe_count;
  logic [15:0] rd;

  dac_update_scheduler_if bus ();

  dac_update_scheduler #(.POSITION(0), .NUM_CH(8), .GAP_CYCLES(2)) dut (
    .ebi_clk (ebi_clk),
    .nReset  (nReset),
    .bus     (bus.slave)
  );

  always #5 ebi_clk = ~ebi_clk;

  task automatic tick();
    @(posedge ebi_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [18:0] a, input logic [15:0] d);
    bus.enable = 1'b1;
    bus.wr     = 1'b1;
    bus.addr   = a;
    bus.data   = d;
    tick();
    bus.wr     = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic readReg(input logic [18:0] a, output logic [15:0] v);
    bus.enable = 1'b1;
    bus.re     = 1'b1;
    bus.addr   = a;
    tick();
    v          = bus.out_data;
    bus.re     = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge ebi_clk);
    nReset = 1'b0;
    @(negedge ebi_clk);
    nReset = 1'b1;
    tick();
  endtask

  // Bounded observation window: records accepted words and LDAC pulses
  task automatic collectWords(input int cycles);
    word_count   = 0;
    strobe_count = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.dac_valid && bus.dac_ready && word_count < 8) begin
        words[word_count] = bus.dac_word;
        word_count++;
      end
      if (bus.ldac_strobe) strobe_count++;
      tick();
    end
  endtask

  initial begin
    nReset        = 1'b0;
    bus.enable    = 1'b0;
    bus.re        = 1'b0;
    bus.wr        = 1'b0;
    bus.addr      = '0;
    bus.data      = '0;
    bus.dac_ready = 1'b0;
    #3;
    checkOutput("rst_valid", 32'(bus.dac_valid), 0);
    checkOutput("rst_word", 32'(bus.dac_word), 0);
    checkOutput("rst_ldac", 32'(bus.ldac_strobe), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_out_data", 32'(bus.out_data), 0);
    @(negedge ebi_clk);
    nReset = 1'b1;
    bus.dac_ready = 1'b1;
    tick();

    // Single write: ISSUE one cycle after the write, two GAP cycles, then LDAC
    applyStimulus(19'h00003, 16'h0ABC);
    checkOutput("single_busy_after_wr", 32'(bus.busy), 1);
    checkOutput("single_not_yet_valid", 32'(bus.dac_valid), 0);
    tick();
    checkOutput("single_valid", 32'(bus.dac_valid), 1);
    checkOutput("single_word", 32'(bus.dac_word), 'h3ABC);
    tick();
    checkOutput("single_valid_drop", 32'(bus.dac_valid), 0);
    checkOutput("single_gap1_busy", 32'(bus.busy), 1);
    tick();
    checkOutput("single_gap2_busy", 32'(bus.busy), 1);
    tick();
    checkOutput("single_busy_fall", 32'(bus.busy), 0);
    checkOutput("single_ldac_early", 32'(bus.ldac_strobe), 0);
    tick();
    checkOutput("single_ldac_pulse", 32'(bus.ldac_strobe), 1);
    tick();
    checkOutput("single_ldac_end", 32'(bus.ldac_strobe), 0);

    // Round-robin from a fresh pointer
    resetDut();
    bus.dac_ready = 1'b1;
    applyStimulus(19'h00008, 16'h0001);
    applyStimulus(19'h00005, 16'h0001);
    applyStimulus(19'h00001, 16'h0002);
    applyStimulus(19'h00006, 16'h0003);
    checkOutput("rr_hold_no_valid", 32'(bus.dac_valid), 0);
    readReg(19'h0000A, rd);
    checkOutput("rr_pending_mask", 32'(rd), 'h0062);
    applyStimulus(19'h00008, 16'h0000);
    collectWords(40);
    checkOutput("rr_count", 32'(word_count), 3);
    checkOutput("rr_word0", 32'(words[0]), 'h1002);
    checkOutput("rr_word1", 32'(words[1]), 'h5001);
    checkOutput("rr_word2", 32'(words[2]), 'h6003);
    checkOutput("rr_ldac_once", 32'(strobe_count), 1);
    checkOutput("rr_idle", 32'(bus.busy), 0);

    // Backpressure: word must hold steady while the shifter is busy
    bus.dac_ready = 1'b0;
    applyStimulus(19'h00004, 16'h0777);
    tick();
    checkOutput("bp_valid", 32'(bus.dac_valid), 1);
    checkOutput("bp_word", 32'(bus.dac_word), 'h4777);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_stable", {15'b0, bus.dac_valid, bus.dac_word}, 'h14777);
    end
    bus.dac_ready = 1'b1;
    tick();
    checkOutput("bp_accepted", 32'(bus.dac_valid), 0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("bp_drained", 32'(bus.busy), 0);

    // Coalescing while held, then a write colliding with the issue cycle
    applyStimulus(19'h00008, 16'h0001);
    applyStimulus(19'h00002, 16'h0111);
    applyStimulus(19'h00002, 16'h0222);
    readReg(19'h00002, rd);
    checkOutput("coal_value", 32'(rd), 'h0222);
    applyStimulus(19'h00008, 16'h0000);
    applyStimulus(19'h00002, 16'h0333);
    collectWords(40);
    checkOutput("coal_count", 32'(word_count), 2);
    checkOutput("coal_word0", 32'(words[0]), 'h2222);
    checkOutput("coal_word1", 32'(words[1]), 'h2333);
    checkOutput("coal_ldac_once", 32'(strobe_count), 1);

    // Register readback
    applyStimulus(19'h00008, 16'h0001);
    applyStimulus(19'h00000, 16'h00AA);
    applyStimulus(19'h00007, 16'h0055);
    readReg(19'h0000A, rd);
    checkOutput("rd_status", 32'(rd), 'h0081);
    readReg(19'h00009, rd);
    checkOutput("rd_id", 32'(rd), 'h5EDA);
    readReg(19'h00008, rd);
    checkOutput("rd_ctrl", 32'(rd), 'h0001);
    readReg(19'h0000B, rd);
    checkOutput("rd_unmapped", 32'(rd), 0);
    readReg(19'h00109, rd);
    checkOutput("rd_wrong_position", 32'(rd), 0);
    readReg(19'h00007, rd);
    checkOutput("rd_ch7", 32'(rd), 'h0055);
    tick();
    checkOutput("rd_no_strobe", 32'(bus.out_data), 0);

    // Asynchronous reset while a word sits in ISSUE
    bus.dac_ready = 1'b0;
    applyStimulus(19'h00008, 16'h0000);
    tick();
    checkOutput("ar_valid", 32'(bus.dac_valid), 1);
    checkOutput("ar_word", 32'(bus.dac_word), 'h7055);
    #2;
    nReset = 1'b0;
    #1;
    checkOutput("ar_valid_drop", 32'(bus.dac_valid), 0);
    checkOutput("ar_busy_drop", 32'(bus.busy), 0);
    checkOutput("ar_ldac", 32'(bus.ldac_strobe), 0);
    checkOutput("ar_word_clear", 32'(bus.dac_word), 0);
    @(negedge ebi_clk);
    nReset = 1'b1;
    bus.dac_ready = 1'b1;
    tick();
    readReg(19'h0000A, rd);
    checkOutput("ar_pending", 32'(rd), 0);
    readReg(19'h00007, rd);
    checkOutput("ar_value7", 32'(rd), 0);
    readReg(19'h00000, rd);
    checkOutput("ar_value0", 32'(rd), 0);
    readReg(19'h00008, rd);
    checkOutput("ar_hold", 32'(rd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
